// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide sequencer.
// Optional multiply early-out is enabled by defining MD_EARLY_OUT_EN.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // MUL's low word does not depend on signedness, so it is treated as unsigned.
    function automatic logic a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage bundle between the pipeline and the multiply/divide sequencer.
interface muldiv_if #(parameter int XLEN = 32);
    // Handshake: the pipeline holds StartE/MDOpE/SrcAE/SrcBE stable while any
    // stall is high; MDValidE is a one-cycle pulse that retires the instruction.
    // FlushE aborts whatever is in flight with no MDValidE pulse.
    logic            StartE;
    logic [2:0]      MDOpE;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            FlushE;
    logic            StallF;
    logic            StallD;
    logic            StallE;
    logic [XLEN-1:0] MDResultE;
    logic            MDValidE;
    logic [1:0]      state;

    modport master (
        output StartE, MDOpE, SrcAE, SrcBE, FlushE,
        input  StallF, StallD, StallE, MDResultE, MDValidE, state
    );

    modport slave (
        input  StartE, MDOpE, SrcAE, SrcBE, FlushE,
        output StallF, StallD, StallE, MDResultE, MDValidE, state
    );
endinterface

// File: rtl/md_iter_core.sv
// Shift-add multiplier and restoring divider on unsigned magnitudes.
// Outputs show the value each register takes after the current step.
module md_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              div_mode,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] acc,
    output logic [XLEN-1:0]   quotient,
    output logic [XLEN-1:0]   remainder,
    output logic              mul_rest_zero
);
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   quot_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   divisor_q;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     diff;
    logic              ge;

    always_comb begin
        acc           = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_rest_zero = (mplier_q[XLEN-1:1] == '0);
        // Partial remainder stays below the divisor, so XLEN+1 bits hold the shift and borrow.
        rem_shift     = {rem_q, quot_q[XLEN-1]};
        diff          = rem_shift - {1'b0, divisor_q};
        ge            = !diff[XLEN];
        remainder     = ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quotient      = {quot_q[XLEN-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
        end else if (load) begin
            acc_q     <= '0;
            mcand_q   <= {{XLEN{1'b0}}, a_mag};
            mplier_q  <= b_mag;
            quot_q    <= a_mag;
            rem_q     <= '0;
            divisor_q <= b_mag;
        end else if (step) begin
            if (div_mode) begin
                quot_q <= quotient;
                rem_q  <= remainder;
            end else begin
                acc_q    <= acc;
                mcand_q  <= {mcand_q[2*XLEN-2:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
            end
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// FSM, fast paths, sign fixup and pipeline stalls for the RV32M unit.
// Define MD_EARLY_OUT_EN to let multiplies exit once the multiplier is exhausted.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  md
);
    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_BUSY = 2'(BUSY);
    localparam logic [1:0] S_DONE = 2'(DONE);

`ifdef MD_EARLY_OUT_EN
    localparam logic EARLY_OUT = 1'b1;
`else
    localparam logic EARLY_OUT = 1'b0;
`endif

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic             neg_q;
    logic             rem_neg_q;
    logic [XLEN-1:0]  result_q;
    logic             valid_q;

    logic              start_ok;
    logic              sa, sb;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, fast;
    logic [XLEN-1:0]   fast_res;
    logic              busy_run, exit_busy;
    logic [2*XLEN-1:0] acc, prod;
    logic [XLEN-1:0]   quotient, remainder, quo_s, rem_s, iter_res;
    logic              mul_rest_zero;

    always_comb begin
        start_ok = (state_q == S_IDLE) && md.StartE && !md.FlushE;
        sa       = a_signed(md.MDOpE) && md.SrcAE[XLEN-1];
        sb       = b_signed(md.MDOpE) && md.SrcBE[XLEN-1];
        a_mag    = sa ? -md.SrcAE : md.SrcAE;
        b_mag    = sb ? -md.SrcBE : md.SrcBE;
        div_zero = is_div(md.MDOpE) && (md.SrcBE == '0);
        div_ovf  = ((md.MDOpE == OP_DIV) || (md.MDOpE == OP_REM))
                   && (md.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (md.SrcBE == '1);
        fast     = div_zero || div_ovf;
        // MDOpE[1] separates remainder ops (REM/REMU) from quotient ops (DIV/DIVU).
        if (div_zero)
            fast_res = md.MDOpE[1] ? md.SrcAE : '1;
        else
            fast_res = md.MDOpE[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    always_comb begin
        busy_run  = (state_q == S_BUSY) && !md.FlushE;
        exit_busy = (cnt_q == CNT_W'(XLEN-1))
                    || (EARLY_OUT && !is_div(op_q) && mul_rest_zero);
        prod      = neg_q ? -acc : acc;
        quo_s     = neg_q ? -quotient : quotient;
        rem_s     = rem_neg_q ? -remainder : remainder;
        if (is_div(op_q))
            iter_res = op_q[1] ? rem_s : quo_s;
        else
            iter_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    md_iter_core #(.XLEN(XLEN)) u_core (
        .clk           (clk),
        .reset         (reset),
        .load          (start_ok && !fast),
        .step          (busy_run),
        .div_mode      (is_div(op_q)),
        .a_mag         (a_mag),
        .b_mag         (b_mag),
        .acc           (acc),
        .quotient      (quotient),
        .remainder     (remainder),
        .mul_rest_zero (mul_rest_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    if (start_ok) begin
                        op_q      <= md.MDOpE;
                        neg_q     <= sa ^ sb;
                        rem_neg_q <= sa;
                        cnt_q     <= '0;
                        if (fast) begin
                            result_q <= fast_res;
                            valid_q  <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (md.FlushE) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (exit_busy) begin
                        result_q <= iter_res;
                        valid_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // A StartE here is the retiring instruction itself, not a new one.
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        md.StallE    = start_ok || busy_run;
        md.StallD    = md.StallE;
        md.StallF    = md.StallE;
        md.MDResultE = result_q;
        md.MDValidE  = valid_q;
        md.state     = state_q;
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: results, latency, stalls, flush and reset.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    muldiv_if #(.XLEN(32)) md ();

    muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Drives one instruction from cycle 0 and follows it to retirement.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        int stall_n;
        logic seen;
        @(negedge clk);
        md.StartE = 1'b1;
        md.MDOpE  = op;
        md.SrcAE  = a;
        md.SrcBE  = b;
        md.FlushE = 1'b0;
        #1;
        cyc     = 0;
        seen    = 1'b0;
        stall_n = (md.StallF && md.StallD && md.StallE) ? 1 : 0;
        while (!seen && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (md.MDValidE) seen = 1'b1;
            else if (md.StallF && md.StallD && md.StallE) stall_n++;
        end
        check_eq({tag, "_lat"}, 32'(cyc), 32'(lat));
        check_eq({tag, "_res"}, md.MDResultE, exp);
        check_eq({tag, "_stall_cycles"}, 32'(stall_n), 32'(lat));
        check_eq({tag, "_stall_done"}, {29'd0, md.StallF, md.StallD, md.StallE}, 32'd0);
        @(negedge clk);
        md.StartE = 1'b0;
        @(posedge clk);
        #1;
        check_eq({tag, "_valid_drop"}, {31'd0, md.MDValidE}, 32'd0);
        check_eq({tag, "_hold"}, md.MDResultE, exp);
    endtask

    initial begin
        int pulses;
        int lat_mul42, lat_mul9, lat_mulhsu;
`ifdef MD_EARLY_OUT_EN
        lat_mul42  = 4;
        lat_mul9   = 3;
        lat_mulhsu = 3;
`else
        lat_mul42  = 33;
        lat_mul9   = 33;
        lat_mulhsu = 33;
`endif
        md.StartE = 1'b0;
        md.MDOpE  = 3'd0;
        md.SrcAE  = 32'd0;
        md.SrcBE  = 32'd0;
        md.FlushE = 1'b0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", {30'd0, md.state}, 32'd0);
        check_eq("rst_valid", {31'd0, md.MDValidE}, 32'd0);
        check_eq("rst_result", md.MDResultE, 32'd0);
        check_eq("rst_stalls", {29'd0, md.StallF, md.StallD, md.StallE}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mul_7x6",    OP_MUL,    32'd7,        32'd6,        32'd42,        lat_mul42);
        run_op("mulh_min",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhu_max",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulhsu_n1",  OP_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, lat_mulhsu);
        run_op("div_m7_2",   OP_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",   OP_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        run_op("div_7_m2",   OP_DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_7_m2",   OP_REM,    32'd7,        32'hFFFF_FFFE, 32'd1,         33);
        run_op("divu_100_7", OP_DIVU,   32'd100,      32'd7,        32'd14,        33);
        run_op("remu_100_7", OP_REMU,   32'd100,      32'd7,        32'd2,         33);
        run_op("divu_by0",   OP_DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        run_op("rem_by0",    OP_REM,    32'd5,        32'd0,        32'd5,         1);
        run_op("div_ovf",    OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",    OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Flush while busy: stalls drop at once, FSM idles, no result pulse.
        @(negedge clk);
        md.StartE = 1'b1;
        md.MDOpE  = OP_MUL;
        md.SrcAE  = 32'd9;
        md.SrcBE  = 32'h8000_0001;
        repeat (10) @(posedge clk);
        @(negedge clk);
        md.FlushE = 1'b1;
        #1;
        check_eq("flush_state_busy", {30'd0, md.state}, 32'(BUSY));
        check_eq("flush_stalls", {29'd0, md.StallF, md.StallD, md.StallE}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("flush_state_idle", {30'd0, md.state}, 32'(IDLE));
        check_eq("flush_valid", {31'd0, md.MDValidE}, 32'd0);
        @(negedge clk);
        md.StartE = 1'b0;
        md.FlushE = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (md.MDValidE) pulses++;
        end
        check_eq("flush_no_pulse", 32'(pulses), 32'd0);

        // Reset mid-operation, then a fresh multiply.
        @(negedge clk);
        md.StartE = 1'b1;
        md.MDOpE  = OP_MUL;
        md.SrcAE  = 32'd5;
        md.SrcBE  = 32'h8000_0001;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        md.StartE = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_state", {30'd0, md.state}, 32'd0);
        check_eq("midrst_valid", {31'd0, md.MDValidE}, 32'd0);
        check_eq("midrst_result", md.MDResultE, 32'd0);
        check_eq("midrst_stalls", {29'd0, md.StallF, md.StallD, md.StallE}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("mul_3x3", OP_MUL, 32'd3, 32'd3, 32'd9, lat_mul9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences an iterative RV32M multiply/divide unit that occupies the Execute stage of the 5-stage pipeline.
- On a start request it latches operands, stalls Fetch/Decode/Execute for the duration of the operation, then presents one valid result for the Execute→Memory register.
- Handles RISC-V divide-by-zero/overflow fast paths and aborts on Execute flush.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- StartE  in  1  M-extension instruction present in Execute.
- MDOpE  in  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- SrcAE  in  XLEN  rs1 operand, already forwarded.
- SrcBE  in  XLEN  rs2 operand, already forwarded.
- FlushE  in  1  Execute flush from the hazard unit.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID register.
- StallE  out  1  hold ID/EX register.
- MDResultE  out  XLEN  result for the ALUResult mux.
- MDValidE  out  1  result valid this cycle; instruction advances.

Behaviour:
- Single clock domain.
- reset is synchronous, active-high.
- Reset values:
  - State IDLE.
  - Counter 0.
  - MDResultE 0.
  - MDValidE 0.
  - All stalls 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If StartE=1 and FlushE=0: latch SrcAE, SrcBE and MDOpE.
  - If the op is a divide-class op with SrcBE=0: go to DONE. Result is quotient all-ones or remainder SrcAE.
  - If the op is DIV/REM with SrcAE=0x80000000 and SrcBE=0xFFFFFFFF: go to DONE. Result is quotient 0x80000000 or remainder 0.
  - Otherwise go to BUSY with counter=0.
- Stalls are combinational:
  - StallF = StallD = StallE = (IDLE & StartE & !FlushE) | BUSY.
  - Deasserted in DONE.
- BUSY, multiply:
  - Shift-add one multiplier bit per cycle.
  - 2·XLEN-bit accumulator on operand magnitudes.
  - Sign correction applied on exit per op signedness: MULHSU treats SrcA as signed and SrcB as unsigned.
- BUSY, divide:
  - Restoring division, one quotient bit per cycle, on magnitudes.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- BUSY → DONE when counter reaches XLEN-1, i.e. XLEN cycles spent in BUSY.
- DONE:
  - MDValidE=1 for exactly one cycle.
  - MDResultE registered and held until the next DONE.
  - Result selection: MUL low word; MULH/MULHSU/MULHU high word.
  - Next state IDLE.
  - A StartE seen in DONE is ignored: it belongs to the same instruction, which is leaving Execute.
- Latency:
  - Normal path: StartE sampled at edge N → MDValidE=1 in cycle N+XLEN+1 (33 cycles for XLEN=32).
  - Fast path: MDValidE=1 in cycle N+1.
- FlushE in BUSY or DONE:
  - Next state IDLE.
  - MDValidE=0 next cycle.
  - Stalls drop combinationally in that cycle.
- FlushE wins over StartE in IDLE.
- reset mid-operation: IDLE next edge; no MDValidE.
- Counter never wraps: exit is forced at XLEN-1.

Optional Feature:
- Macro: MD_EARLY_OUT_EN.
- When defined, multiply leaves BUSY as soon as the remaining unshifted multiplier magnitude is zero, after at least one iteration. Latency becomes 1 + (index of highest set bit of |B|) + 1 cycles.
- Divide is unaffected.
- When undefined, every non-fast-path op takes exactly XLEN BUSY cycles.

Decomposition:
- Package muldiv_pkg holds:
  - md_op_e enum for the 8 ops.
  - md_state_e enum {IDLE, BUSY, DONE}.
  - XLEN_DEFAULT constant.
  - Helper function is_div(op).
- Sub-module md_iter_core holds the shift/accumulate/restore datapath: step, load and op inputs; acc/quotient/remainder outputs.
- The FSM, counter, fast-path detection, sign fixup and stall logic stay in muldiv_sequencer.

Test Plan:
- MUL: SrcA=7, SrcB=6, StartE at cycle 0 → StallE high in cycles 0–32; MDValidE=1 in cycle 33 with MDResultE=42. With MD_EARLY_OUT_EN the result is still 42, in cycle 4.
- MULH: 0x80000000 × 0x80000000 → MDResultE=0x40000000. MULHU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFF (−1). DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU x/0 with x=5 → result 0xFFFFFFFF, MDValidE in cycle 1. REM 5/0 → 5. DIV 0x80000000/−1 → 0x80000000 in cycle 1.
- FlushE at BUSY cycle 10 → state IDLE, stalls 0 that cycle; no MDValidE pulse over the next 40 cycles.
- reset asserted at BUSY cycle 5 → all outputs 0 next edge. A new MUL 3×3 then completes normally with result 9.
